serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 153 +++++++++++++++
 tb/tb_serial_subtractor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first.
// A start in IDLE captures the operands; WIDTH RUN cycles later the result is
// latched into diff/bout and done pulses for the single DONE cycle.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed overflow output.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    // One extra bit so the counter reaches WIDTH without wrapping.
    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   part_q;
    logic               br_q;
    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q;
    logic               d_bit;
    logic               br_next;
    logic               last_bit;
    logic [WIDTH-1:0]   part_next;

`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q;
    logic               b_msb_q;
    logic               ovf_q;
`endif

    // Full-subtractor cell and the shifted partial result for this cycle.
    always_comb begin
        d_bit     = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_next   = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        part_next = {d_bit, part_q[WIDTH-1:1]};
        last_bit  = (cnt_q == CntW'(WIDTH - 1));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and status outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath: operand capture, per-bit shift, result latch on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            part_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        br_q    <= bin;
                        part_q  <= '0;
                        cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        // MSBs are gone from the shift registers by the end.
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1];
`endif
                    end
                end
                StRun: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    part_q <= part_next;
                    br_q   <= br_next;
                    cnt_q  <= cnt_q + CntW'(1);
                    if (last_bit) begin
                        diff_q <= part_next;
                        bout_q <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q  <= (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): a scoreboard queue is
// filled when a start is accepted and drained when done is seen.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         overflow;
`endif

    int           n_tests = 0;
    int           n_fail  = 0;
    exp_t         exp_q[$];
    exp_t         exp_cur;
    logic [W-1:0] last_diff = '0;

    serial_subtractor #(
        .WIDTH(W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow(overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference computed arithmetically on a WIDTH+1 bit value.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        exp_t       e;
        r    = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
        e.d  = r[W-1:0];
        e.bo = r[W];
        e.ov = (x[W-1] ^ y[W-1]) & (r[W-1] ^ x[W-1]);
        return e;
    endfunction

    // Scoreboard drain on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                exp_cur = exp_q.pop_front();
                check("diff", diff, exp_cur.d);
                check("bout", bout, exp_cur.bo);
`ifdef SERIAL_SUB_OVF_EN
                check("overflow", overflow, exp_cur.ov);
`endif
                last_diff = exp_cur.d;
            end
        end
    end

    // One full operation; operands are scrambled after capture.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input bit rel);
        int busy_cycles;
        int lat;
        bit seen;
        @(negedge clk);
        if (rel) rst_n = 1'b1;
        check("done_pulse_width", done, 0);
        a = x;
        b = y;
        bin = c;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(x, y, c));
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        bin = 1'($urandom);
        seen = 0;
        busy_cycles = 0;
        lat = 0;
        for (int cyc = 1; cyc <= W + 4 && !seen; cyc++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (cyc == 1) check("hold_diff_run", diff, last_diff);
            // Stray start while busy must be ignored.
            start = (cyc == 2);
            if (done) begin
                seen = 1;
                lat = cyc;
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("latency", lat, W + 1);
        check("busy_cycles", busy_cycles, W);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", overflow, 0);
`endif
        repeat (2) @(posedge clk);

        // Start accepted on the first edge after release.
        run_op(8'h05, 8'h03, 1'b0, 1'b1);
        run_op(8'h03, 8'h05, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b0);
        run_op(8'h10, 8'h01, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h00, 8'hFF, 1'b0, 1'b0);
        run_op(8'h7F, 8'h80, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        // start held high: one accept per WIDTH+2 cycles, a changed mid-run.
        @(negedge clk);
        a = 8'h0A;
        b = 8'h04;
        bin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(8'h0A, 8'h04, 1'b0));
        for (int cyc = 1; cyc <= W + 2; cyc++) begin
            @(negedge clk);
            if (cyc == 3) a = 8'hFF;
            check("held_busy", busy, 32'(cyc <= W));
            check("held_done", done, 32'(cyc == W + 1));
        end
        @(posedge clk);
        exp_q.push_back(model(8'hFF, 8'h04, 1'b0));
        for (int cyc = 1; cyc <= W + 2; cyc++) begin
            @(negedge clk);
            check("held2_busy", busy, 32'(cyc <= W));
            check("held2_done", done, 32'(cyc == W + 1));
            if (cyc == W + 2) start = 1'b0;
        end

        // Reset during RUN cycle 4 aborts with no done.
        @(negedge clk);
        a = 8'h55;
        b = 8'h22;
        bin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_was_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", overflow, 0);
`endif
        last_diff = '0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        run_op(8'h20, 8'h10, 1'b0, 1'b1);

        repeat (W + 4) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
